cohort_noc2_encoder: RTL and testbench
======================================

Name: cohort_noc2_encoder

Overview:
- Serializes translated memory requests from the Cohort translator output into 64-bit NoC2 flits for the tile's L2/NoC injection point.
- Sits directly downstream of the request sink of the Cohort accelerator top level.
- Accepts one request per valid/ready handshake, emits a 3-flit header plus 0–2 data flits, and keeps a flit counter for performance monitoring.

Parameters:
- MSG_LOAD, 8'd14: msg type for req_type 0 (load).
- MSG_STORE, 8'd15: msg type for req_type 1 (store).
- MSG_AMO, 8'd36: msg type for req_type 2 (atomic).
- CNT_W, 32: width of the flit counter.

Ports:
- clk  in  1  Clock.
- rst  in  1  Synchronous reset, active-high.
- req_valid  in  1  Request valid.
- req_ready  out  1  Request accepted when req_valid & req_ready.
- req_type  in  2  0 load, 1 store, 2 atomic, 3 illegal.
- req_mshrid  in  8  MSHR id.
- req_address  in  48  Physical address.
- req_size  in  3  Access size code.
- req_homeid  in  30  Destination: {chipid[29:16], x[15:8], y[7:0]}.
- req_write_mask  in  8  Byte mask.
- req_data_0  in  64  First data word.
- req_data_1  in  64  Second data word.
- src_chipid  in  14  Own chip id (quasi-static).
- src_x  in  8  Own x (quasi-static).
- src_y  in  8  Own y (quasi-static).
- noc_valid  out  1  Flit valid.
- noc_data  out  64  Flit payload.
- noc_ready  in  1  Downstream ready.
- err_illegal  out  1  One-cycle pulse when an illegal req_type is accepted.
- flit_count  out  CNT_W  Number of flits sent (wraps).

Behaviour:
- Reset values: state IDLE; req_ready=1; noc_valid=0; noc_data=0; err_illegal=0; flit_count=0. All latched request fields are cleared.
- Reset wins over every other event, including a handshake in progress. A partial packet is abandoned and no further flits are emitted.
- States and transitions:
  - IDLE -> HDR0 on accept of a legal request.
  - HDR0 -> HDR1 -> HDR2 -> DATA0 -> DATA1. Each transition occurs only on noc_valid & noc_ready.
  - The last flit is HDR2 for a load, DATA0 for a store, and DATA1 for an atomic.
  - On the last-flit handshake, go to IDLE. If a new legal request is accepted in that same cycle, go directly to HDR0 instead.
- req_ready = (state==IDLE) | (last flit & noc_ready). This gives zero-bubble back-to-back packets.
- All request fields are registered on accept. noc_data is driven only from registers, so input changes after accept have no effect.
- Latency: request accepted in cycle N -> HDR0 valid in cycle N+1.
- noc_valid stays high from HDR0 through the last flit. While noc_ready=0, noc_data is held stable.
- Flit formats:
  - HDR0: [63:50] homeid chipid, [49:42] homeid x, [41:34] homeid y, [33:30] 4'b0, [29:22] payload length (2 + number of data flits: 2/3/4), [21:14] msg type, [13:6] mshrid, [5:0] 0.
  - HDR1: [63:16] address, [15:8] write_mask, [7:5] size, [4:0] 0.
  - HDR2: [63:50] src_chipid, [49:42] src_x, [41:34] src_y, [33:0] 0.
  - DATA0 = data_0; DATA1 = data_1.
- Illegal req_type=3:
  - The request is accepted (ready behaves as for a legal request).
  - No flits are emitted and the state stays IDLE.
  - err_illegal pulses high the cycle after accept.
- flit_count increments by 1 on every noc_valid & noc_ready, and wraps from all-ones to 0.
- noc_data shows the current flit while valid. It is don't-care-free: it is driven to 0 in IDLE.

Test Plan:
- Load, req_type=0, mshrid=8'h83, address=48'h0000_8000_1040, homeid={14'd0,8'd2,8'd1}, noc_ready=1 -> 3 flits in cycles N+1..N+3:
  - HDR0[29:22]=2 and HDR0[21:14]=14.
  - HDR1[63:16]=48'h0000_8000_1040.
  - flit_count=3.
- Atomic, req_type=2, data_0=64'hAAAA, data_1=64'h5555 -> 5 flits, length=4, msg type=36. DATA0=64'hAAAA, DATA1=64'h5555.
- Backpressure: a store with noc_ready toggling 1,0,0,1,1,... -> each flit is held stable while ready=0, exactly 3+1 flits are sent, and req_ready=0 throughout.
- Back-to-back: two loads, req_valid held high, noc_ready=1 -> 6 consecutive valid flit cycles with no gap; the second HDR0 carries the second mshrid.
- Illegal: req_type=3 -> req_ready=1, err_illegal high for exactly one cycle, noc_valid stays 0, flit_count unchanged.
- Reset mid-packet: assert rst during DATA0 of an atomic -> the next cycle has noc_valid=0, req_ready=1, flit_count=0; a subsequent load emits a clean 3-flit packet.

Source files
------------

// File: rtl/cohort_noc2_encoder.sv
// ============================================================================
// cohort_noc2_encoder: serializes one translated memory request into a
// 3-flit NoC2 header plus 0-2 data flits. Revision: 1.0
// ============================================================================
`default_nettype none

module cohort_noc2_encoder #(
  parameter logic [7:0] MSG_LOAD  = 8'd14,
  parameter logic [7:0] MSG_STORE = 8'd15,
  parameter logic [7:0] MSG_AMO   = 8'd36,
  parameter int         CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_type,
  input  logic [7:0]       req_mshrid,
  input  logic [47:0]      req_address,
  input  logic [2:0]       req_size,
  input  logic [29:0]      req_homeid,
  input  logic [7:0]       req_write_mask,
  input  logic [63:0]      req_data_0,
  input  logic [63:0]      req_data_1,
  input  logic [13:0]      src_chipid,
  input  logic [7:0]       src_x,
  input  logic [7:0]       src_y,
  output logic             noc_valid,
  output logic [63:0]      noc_data,
  input  logic             noc_ready,
  output logic             err_illegal,
  output logic [CNT_W-1:0] flit_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_HDR2  = 3'd3,
    S_DATA0 = 3'd4,
    S_DATA1 = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [7:0]       mshrid_q, mshrid_d;
  logic [47:0]      address_q, address_d;
  logic [2:0]       size_q, size_d;
  logic [29:0]      homeid_q, homeid_d;
  logic [7:0]       mask_q, mask_d;
  logic [63:0]      data0_q, data0_d;
  logic [63:0]      data1_q, data1_d;
  logic [13:0]      chipid_q, chipid_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       last_flit;
  logic       accept;
  logic       take_new;
  logic       flit_hs;
  logic [7:0] pay_len;
  logic [7:0] msg_type;

  always_comb begin
    state_d   = state_q;
    type_d    = type_q;
    mshrid_d  = mshrid_q;
    address_d = address_q;
    size_d    = size_q;
    homeid_d  = homeid_q;
    mask_d    = mask_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    chipid_d  = chipid_q;
    x_d       = x_q;
    y_d       = y_q;

    last_flit = ((state_q == S_HDR2)  && (type_q == 2'd0)) ||
                ((state_q == S_DATA0) && (type_q == 2'd1)) ||
                ((state_q == S_DATA1) && (type_q == 2'd2));
    noc_valid = (state_q != S_IDLE);
    req_ready = (state_q == S_IDLE) || (last_flit && noc_ready);
    accept    = req_valid && req_ready;
    take_new  = accept && (req_type != 2'd3);
    flit_hs   = noc_valid && noc_ready;

    if (accept) begin
      type_d    = req_type;
      mshrid_d  = req_mshrid;
      address_d = req_address;
      size_d    = req_size;
      homeid_d  = req_homeid;
      mask_d    = req_write_mask;
      data0_d   = req_data_0;
      data1_d   = req_data_1;
      chipid_d  = src_chipid;
      x_d       = src_x;
      y_d       = src_y;
    end

    // Last-flit handshake may chain straight into the next packet's HDR0.
    if (state_q == S_IDLE) begin
      if (take_new) state_d = S_HDR0;
    end else if (noc_ready) begin
      if (last_flit) begin
        state_d = take_new ? S_HDR0 : S_IDLE;
      end else begin
        unique case (state_q)
          S_HDR0:  state_d = S_HDR1;
          S_HDR1:  state_d = S_HDR2;
          S_HDR2:  state_d = S_DATA0;
          S_DATA0: state_d = S_DATA1;
          default: state_d = S_IDLE;
        endcase
      end
    end

    err_d   = accept && (req_type == 2'd3);
    count_d = flit_hs ? count_q + {{(CNT_W-1){1'b0}}, 1'b1} : count_q;

    unique case (type_q)
      2'd1:    begin pay_len = 8'd3; msg_type = MSG_STORE; end
      2'd2:    begin pay_len = 8'd4; msg_type = MSG_AMO;   end
      default: begin pay_len = 8'd2; msg_type = MSG_LOAD;  end
    endcase

    unique case (state_q)
      S_HDR0:  noc_data = {homeid_q[29:16], homeid_q[15:8], homeid_q[7:0], 4'b0,
                           pay_len, msg_type, mshrid_q, 6'b0};
      S_HDR1:  noc_data = {address_q, mask_q, size_q, 5'b0};
      S_HDR2:  noc_data = {chipid_q, x_q, y_q, 34'b0};
      S_DATA0: noc_data = data0_q;
      S_DATA1: noc_data = data1_q;
      default: noc_data = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      type_q    <= 2'd0;
      mshrid_q  <= 8'd0;
      address_q <= 48'd0;
      size_q    <= 3'd0;
      homeid_q  <= 30'd0;
      mask_q    <= 8'd0;
      data0_q   <= 64'd0;
      data1_q   <= 64'd0;
      chipid_q  <= 14'd0;
      x_q       <= 8'd0;
      y_q       <= 8'd0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      mshrid_q  <= mshrid_d;
      address_q <= address_d;
      size_q    <= size_d;
      homeid_q  <= homeid_d;
      mask_q    <= mask_d;
      data0_q   <= data0_d;
      data1_q   <= data1_d;
      chipid_q  <= chipid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign err_illegal = err_q;
  assign flit_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_cohort_noc2_encoder.sv
// ============================================================================
// tb_cohort_noc2_encoder: randomized and directed stimulus checked against a
// flit-queue reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cohort_noc2_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_type = 2'd0;
  logic [7:0]  req_mshrid = 8'd0;
  logic [47:0] req_address = 48'd0;
  logic [2:0]  req_size = 3'd0;
  logic [29:0] req_homeid = 30'd0;
  logic [7:0]  req_write_mask = 8'd0;
  logic [63:0] req_data_0 = 64'd0;
  logic [63:0] req_data_1 = 64'd0;
  logic [13:0] src_chipid = 14'h2a5;
  logic [7:0]  src_x = 8'h3c;
  logic [7:0]  src_y = 8'hc3;
  logic        noc_valid;
  logic [63:0] noc_data;
  logic        noc_ready = 1'b1;
  logic        err_illegal;
  logic [31:0] flit_count;

  int n_total = 0;
  int n_pass  = 0;

  cohort_noc2_encoder dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_type       (req_type),
    .req_mshrid     (req_mshrid),
    .req_address    (req_address),
    .req_size       (req_size),
    .req_homeid     (req_homeid),
    .req_write_mask (req_write_mask),
    .req_data_0     (req_data_0),
    .req_data_1     (req_data_1),
    .src_chipid     (src_chipid),
    .src_x          (src_x),
    .src_y          (src_y),
    .noc_valid      (noc_valid),
    .noc_data       (noc_data),
    .noc_ready      (noc_ready),
    .err_illegal    (err_illegal),
    .flit_count     (flit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Downstream ready: always-on, fixed 1,0,0,1,1 pattern, or random.
  int rdy_mode = 0;
  int pat_idx  = 0;
  bit rdy_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      1: begin noc_ready = rdy_pat[pat_idx]; pat_idx = (pat_idx + 1) % 5; end
      2: noc_ready = ($urandom_range(0, 3) != 0);
      default: noc_ready = 1'b1;
    endcase
  end

  // Reference model: the flits still owed for the packet in flight.
  logic [63:0] exp_q[$];
  logic [31:0] exp_cnt  = 32'd0;
  logic        exp_err  = 1'b0;
  bit          started  = 1'b0;

  always @(negedge clk) begin
    logic        exp_valid;
    logic        exp_ready;
    int          ndata;
    logic [7:0]  msg;
    logic [63:0] h0, h1, h2;
    exp_valid = (exp_q.size() != 0);
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && noc_ready);
    if (started) begin
      check("noc_valid",   {63'd0, noc_valid},   {63'd0, exp_valid});
      check("noc_data",    noc_data,             exp_valid ? exp_q[0] : 64'd0);
      check("req_ready",   {63'd0, req_ready},   {63'd0, exp_ready});
      check("err_illegal", {63'd0, err_illegal}, {63'd0, exp_err});
      check("flit_count",  {32'd0, flit_count},  {32'd0, exp_cnt});
    end
    if (rst) begin
      exp_q.delete();
      exp_cnt = 32'd0;
      exp_err = 1'b0;
      started = 1'b1;
    end else if (started) begin
      if (exp_valid && noc_ready) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 32'd1;
      end
      exp_err = 1'b0;
      if (req_valid && exp_ready) begin
        if (req_type == 2'd3) begin
          exp_err = 1'b1;
        end else begin
          ndata = int'(req_type);
          msg   = (req_type == 2'd0) ? 8'd14 : (req_type == 2'd1) ? 8'd15 : 8'd36;
          h0 = (64'(req_homeid[29:16]) << 50) | (64'(req_homeid[15:8]) << 42) |
               (64'(req_homeid[7:0]) << 34) | (64'(2 + ndata) << 22) |
               (64'(msg) << 14) | (64'(req_mshrid) << 6);
          h1 = (64'(req_address) << 16) | (64'(req_write_mask) << 8) | (64'(req_size) << 5);
          h2 = (64'(src_chipid) << 50) | (64'(src_x) << 42) | (64'(src_y) << 34);
          exp_q.push_back(h0);
          exp_q.push_back(h1);
          exp_q.push_back(h2);
          if (ndata >= 1) exp_q.push_back(req_data_0);
          if (ndata >= 2) exp_q.push_back(req_data_1);
        end
      end
    end
  end

  task automatic scramble();
    req_type       = 2'($urandom);
    req_mshrid     = 8'($urandom);
    req_address    = {16'($urandom), 32'($urandom)};
    req_size       = 3'($urandom);
    req_homeid     = 30'($urandom);
    req_write_mask = 8'($urandom);
    req_data_0     = {32'($urandom), 32'($urandom)};
    req_data_1     = {32'($urandom), 32'($urandom)};
  endtask

  // Presents a request and holds it until accepted; fields are scrambled
  // right after accept so the DUT must rely on its registered copy.
  task automatic send_req(input logic [1:0] t, input logic [7:0] id, input logic [47:0] addr,
                          input logic [29:0] home, input logic [63:0] d0,
                          input logic [63:0] d1, input bit keep);
    bit got;
    scramble();
    req_type    = t;
    req_mshrid  = id;
    req_address = addr;
    req_homeid  = home;
    req_data_0  = d0;
    req_data_1  = d1;
    req_valid   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) got = 1'b1;
    end
    if (!got) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
    scramble();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      scramble();
    end
  endtask

  initial begin
    scramble();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send_req(2'd0, 8'h83, 48'h0000_8000_1040, {14'd0, 8'd2, 8'd1}, 64'd0, 64'd0, 1'b0);
    repeat (4) @(negedge clk);
    check("load_count", {32'd0, flit_count}, 64'd3);
    idle(1);

    send_req(2'd2, 8'h21, 48'h1234_5678_9ab8, 30'h0abc_1234, 64'hAAAA, 64'h5555, 1'b0);
    idle(6);

    rdy_mode = 1;
    send_req(2'd1, 8'h42, 48'h0000_0000_0100, 30'h0000_0203, 64'hdead_beef_0000_0001,
             64'd0, 1'b0);
    idle(12);
    rdy_mode = 0;
    idle(2);

    send_req(2'd0, 8'h11, 48'h0000_0000_2000, 30'h0000_0101, 64'd0, 64'd0, 1'b1);
    send_req(2'd0, 8'h22, 48'h0000_0000_3000, 30'h0000_0102, 64'd0, 64'd0, 1'b0);
    idle(8);

    send_req(2'd3, 8'h99, 48'h0000_0000_4000, 30'h0000_0000, 64'd0, 64'd0, 1'b0);
    idle(3);
    @(negedge clk);
    check("illegal_count", {32'd0, flit_count}, 64'd18);

    @(posedge clk);
    #1;
    send_req(2'd2, 8'h5a, 48'h0000_0000_5000, 30'h0000_0304, 64'h1111, 64'h2222, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_count", {32'd0, flit_count}, 64'd0);
    check("rst_valid", {63'd0, noc_valid}, 64'd0);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    send_req(2'd0, 8'h07, 48'h0000_0000_6000, 30'h0000_0506, 64'd0, 64'd0, 1'b0);
    idle(5);
    @(negedge clk);
    check("post_rst_count", {32'd0, flit_count}, 64'd3);

    @(posedge clk);
    #1;
    rdy_mode = 2;
    for (int k = 0; k < 300; k++) begin
      send_req(2'($urandom), 8'($urandom), {16'($urandom), 32'($urandom)}, 30'($urandom),
               {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
               bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    req_valid = 1'b0;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
